// File: rtl/bit_to_byte_ram_ctrl_pkg.sv
// Shared RAM geometry, FSM encoding and port-A bit addressing for the bit-in / byte-out buffer.
package bit_to_byte_ram_ctrl_pkg;

    localparam int DEPTH_BITS = 4096;
    localparam int ABITS_A    = 12;
    localparam int ABITS_B    = 9;
    localparam int BYTE_W     = 8;
    localparam int LVL_W      = ABITS_A + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Bit lane inside the byte word is mirrored when the first bit must land in the MSB.
    function automatic logic [ABITS_A-1:0] bit_addr(input logic [ABITS_A-1:0] wp,
                                                    input logic              msb_first);
        logic [2:0] lane;
        lane = msb_first ? (3'd7 - wp[2:0]) : wp[2:0];
        return {wp[ABITS_A-1:3], lane};
    endfunction

endpackage

// File: rtl/bit_to_byte_ram_ctrl.sv
// Serial-to-parallel FIFO controller driving a 4096x1 / 512x8 dual-port RAM:
// one bit per cycle in on port A, whole bytes out of port B with valid/ready.
module bit_to_byte_ram_ctrl
    import bit_to_byte_ram_ctrl_pkg::*;
#(
    parameter bit          MSB_FIRST   = 1'b0,
    parameter int unsigned AFULL_LEVEL = 4032
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               BIT_IN,
    input  logic               BIT_VALID,
    output logic               BIT_READY,
    output logic [BYTE_W-1:0]  BYTE_OUT,
    output logic               BYTE_VALID,
    input  logic               BYTE_READY,
    output logic [LVL_W-1:0]   LEVEL,
    output logic               AFULL,
    output logic [ABITS_A-1:0] ADDRA,
    output logic               DIA,
    output logic               ENA,
    output logic               WEA,
    output logic               RSTA,
    output logic [ABITS_B-1:0] ADDRB,
    output logic               ENB,
    output logic               WEB,
    output logic [BYTE_W-1:0]  DIB,
    output logic               RSTB,
    input  logic [BYTE_W-1:0]  DOB
);

    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH_BITS);
    localparam logic [LVL_W-1:0] AFULL_LVL = LVL_W'(AFULL_LEVEL);

    logic [LVL_W-1:0]  wp_q, wp_d;
    logic [ABITS_B:0]  rp_q, rp_d;
    state_t            state_q, state_d;
    logic [LVL_W-1:0]  level;
    logic              wr_en;
    logic              avail;
    logic              fetch;

    // The fetched byte leaves the RAM array for the DOB register, so its space is freed at fetch.
    always_comb begin
        level   = wp_q - {rp_q, 3'b000};
        wr_en   = BIT_VALID && (level != FULL_LVL);
        avail   = (level >= LVL_W'(BYTE_W));
        fetch   = avail && ((state_q == ST_IDLE) || BYTE_READY);
        wp_d    = wp_q + LVL_W'(wr_en);
        rp_d    = rp_q + (ABITS_B + 1)'(fetch);
        state_d = state_q;
        if (fetch) begin
            state_d = ST_HOLD;
        end else if (BYTE_READY) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp_q    <= '0;
            rp_q    <= '0;
            state_q <= ST_IDLE;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            state_q <= state_d;
        end
    end

    // ENB stays low in HOLD unless a new fetch issues, keeping DOB stable under backpressure.
    assign BIT_READY  = (level != FULL_LVL);
    assign BYTE_VALID = (state_q == ST_HOLD);
    assign BYTE_OUT   = DOB;
    assign LEVEL      = level;
    assign AFULL      = (level >= AFULL_LVL);

    assign ENA   = wr_en;
    assign WEA   = wr_en;
    assign DIA   = BIT_IN;
    assign ADDRA = bit_addr(wp_q[ABITS_A-1:0], MSB_FIRST);
    assign RSTA  = 1'b0;

    assign ENB   = fetch;
    assign ADDRB = rp_q[ABITS_B-1:0];
    assign WEB   = 1'b0;
    assign DIB   = '0;
    assign RSTB  = 1'b0;

endmodule

// File: tb/tb_bit_to_byte_ram_ctrl.sv
// Bench: two controllers (LSB-first and MSB-first), each with a 4096x1 / 512x8 RAM model,
// checked against a bit-queue reference model.
module tb_bit_to_byte_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        bi0, bv0, brdy0, byv0, br0, af0, dia0, ena0, wea0, rsta0, enb0, web0, rstb0;
    logic [7:0]  bo0, dib0, dob0;
    logic [12:0] lvl0;
    logic [11:0] addra0;
    logic [8:0]  addrb0;

    logic        bi1, bv1, brdy1, byv1, br1, af1, dia1, ena1, wea1, rsta1, enb1, web1, rstb1;
    logic [7:0]  bo1, dib1, dob1;
    logic [12:0] lvl1;
    logic [11:0] addra1;
    logic [8:0]  addrb1;

    bit_to_byte_ram_ctrl #(.MSB_FIRST(1'b0), .AFULL_LEVEL(4032)) u0 (
        .CLK(clk), .RST(rst), .BIT_IN(bi0), .BIT_VALID(bv0), .BIT_READY(brdy0),
        .BYTE_OUT(bo0), .BYTE_VALID(byv0), .BYTE_READY(br0), .LEVEL(lvl0), .AFULL(af0),
        .ADDRA(addra0), .DIA(dia0), .ENA(ena0), .WEA(wea0), .RSTA(rsta0),
        .ADDRB(addrb0), .ENB(enb0), .WEB(web0), .DIB(dib0), .RSTB(rstb0), .DOB(dob0));

    bit_to_byte_ram_ctrl #(.MSB_FIRST(1'b1), .AFULL_LEVEL(4032)) u1 (
        .CLK(clk), .RST(rst), .BIT_IN(bi1), .BIT_VALID(bv1), .BIT_READY(brdy1),
        .BYTE_OUT(bo1), .BYTE_VALID(byv1), .BYTE_READY(br1), .LEVEL(lvl1), .AFULL(af1),
        .ADDRA(addra1), .DIA(dia1), .ENA(ena1), .WEA(wea1), .RSTA(rsta1),
        .ADDRB(addrb1), .ENB(enb1), .WEB(web1), .DIB(dib1), .RSTB(rstb1), .DOB(dob1));

    // Dual-port RAM models: byte word b, bit k lives at bit address 8*b+k.
    logic mem0 [0:4095];
    logic mem1 [0:4095];
    always @(posedge clk) begin
        if (ena0 && wea0) mem0[addra0] <= dia0;
        if (enb0) for (int k = 0; k < 8; k++) dob0[k] <= mem0[{addrb0, 3'(k)}];
        if (ena1 && wea1) mem1[addra1] <= dia1;
        if (enb1) for (int k = 0; k < 8; k++) dob1[k] <= mem1[{addrb1, 3'(k)}];
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model for u0: FIFO of accepted bits plus the one byte held at the output.
    bit       bitq[$];
    bit       holding;
    bit [7:0] hold_byte;

    task automatic model_reset();
        bitq.delete();
        holding   = 1'b0;
        hold_byte = '0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit r);
        bit wr, fe;
        wr = v && (bitq.size() != 4096);
        fe = (bitq.size() >= 8) && (!holding || r);
        if (fe) begin
            for (int k = 0; k < 8; k++) hold_byte[k] = bitq.pop_front();
            holding = 1'b1;
        end else if (r) begin
            holding = 1'b0;
        end
        if (wr) bitq.push_back(b);
    endtask

    task automatic drive0(input bit v, input bit b, input bit r);
        @(negedge clk);
        bv0 = v; bi0 = b; br0 = r;
        #1;
    endtask

    task automatic drive1(input bit v, input bit b, input bit r);
        @(negedge clk);
        bv1 = v; bi1 = b; br1 = r;
        #1;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        bv0 = 0; br0 = 0; bv1 = 0; br1 = 0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bit [7:0] pat;
        pat = 8'b0000_1101;
        n_cmp++;
        if (lvl0 !== 13'd0 || brdy0 !== 1'b1 || byv0 !== 1'b0 || af0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state lvl=%0d rdy=%b vld=%b af=%b want 0/1/0/0", lvl0, brdy0, byv0, af0);
        end
        for (int i = 0; i < 12; i++) begin
            drive0(1, 1'($urandom_range(0, 1)), 0);
            model_step(bv0, bi0, br0);
        end
        drive0(0, 0, 0);
        model_step(0, 0, 0);
        n_cmp++;
        if (byv0 !== 1'b1 || lvl0 !== 13'd4) begin
            n_err++;
            $display("FAIL pre_reset vld=%b lvl=%0d want 1/4", byv0, lvl0);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (byv0 !== 1'b0 || lvl0 !== 13'd0 || brdy0 !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset vld=%b lvl=%0d rdy=%b want 0/0/1", byv0, lvl0, brdy0);
        end
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            drive0(1, pat[i], 0);
            model_step(bv0, bi0, br0);
        end
        drive0(0, 0, 0);
        n_cmp++;
        if (byv0 !== 1'b0 || lvl0 !== 13'd8) begin
            n_err++;
            $display("FAIL lsb_latency vld=%b lvl=%0d want 0/8", byv0, lvl0);
        end
        model_step(0, 0, 0);
        drive0(0, 0, 1);
        n_cmp++;
        if (byv0 !== 1'b1 || bo0 !== 8'h0D || lvl0 !== 13'd0) begin
            n_err++;
            $display("FAIL lsb_byte vld=%b byte=%h lvl=%0d want 1/0d/0", byv0, bo0, lvl0);
        end
        model_step(0, 0, 1);
    endtask

    task automatic test_msb_first();
        bit [7:0] pat;
        pat = 8'b0000_1101;
        for (int i = 0; i < 8; i++) begin
            drive1(1, pat[i], 0);
            if (i == 0) begin
                n_cmp++;
                if (addra1 !== 12'd7 || ena1 !== 1'b1) begin
                    n_err++;
                    $display("FAIL msb_addra addra=%0d ena=%b want 7/1", addra1, ena1);
                end
            end
        end
        drive1(0, 0, 0);
        n_cmp++;
        if (byv1 !== 1'b0 || lvl1 !== 13'd8) begin
            n_err++;
            $display("FAIL msb_latency vld=%b lvl=%0d want 0/8", byv1, lvl1);
        end
        drive1(0, 0, 1);
        n_cmp++;
        if (byv1 !== 1'b1 || bo1 !== 8'hB0) begin
            n_err++;
            $display("FAIL msb_byte vld=%b byte=%h want 1/b0", byv1, bo1);
        end
        drive1(0, 0, 0);
        n_cmp++;
        if (byv1 !== 1'b0 || lvl1 !== 13'd0) begin
            n_err++;
            $display("FAIL msb_consume vld=%b lvl=%0d want 0/0", byv1, lvl1);
        end
    endtask

    task automatic test_fill();
        int nacc, ncons, n, cyc;
        bit b;
        pulse_rst();
        nacc = 0; n = 0; cyc = 0;
        while (cyc < 4200) begin
            b = 1'(((n / 8) & 255) >> (n % 8));
            drive0(1, b, 0);
            n_cmp++;
            if (lvl0 !== 13'(bitq.size()) || brdy0 !== (bitq.size() != 4096) ||
                byv0 !== holding || af0 !== (bitq.size() >= 4032)) begin
                n_err++;
                $display("FAIL fill_state cyc=%0d lvl=%0d rdy=%b vld=%b af=%b want lvl=%0d",
                         cyc, lvl0, brdy0, byv0, af0, bitq.size());
            end
            if (ena0) nacc++;
            if (bitq.size() != 4096) n++;
            model_step(1, b, 0);
            cyc++;
        end
        drive0(1, 1, 0);
        n_cmp++;
        if (lvl0 !== 13'd4096 || brdy0 !== 1'b0 || af0 !== 1'b1 || ena0 !== 1'b0 || nacc != 4104) begin
            n_err++;
            $display("FAIL full lvl=%0d rdy=%b af=%b ena=%b accepted=%0d want 4096/0/1/0/4104",
                     lvl0, brdy0, af0, ena0, nacc);
        end
        model_step(1, 1, 0);
        ncons = 0;
        for (int c = 0; c < 600; c++) begin
            drive0(0, 0, 1);
            n_cmp++;
            if (lvl0 !== 13'(bitq.size()) || byv0 !== holding || brdy0 !== (bitq.size() != 4096)) begin
                n_err++;
                $display("FAIL drain_state cyc=%0d lvl=%0d vld=%b want lvl=%0d vld=%b",
                         c, lvl0, byv0, bitq.size(), holding);
            end
            if (byv0) begin
                n_cmp++;
                if (bo0 !== 8'(ncons)) begin
                    n_err++;
                    $display("FAIL drain_byte idx=%0d got=%h want=%h", ncons, bo0, 8'(ncons));
                end
                ncons++;
            end
            model_step(0, 0, 1);
        end
        n_cmp++;
        if (ncons != 513 || lvl0 !== 13'd0) begin
            n_err++;
            $display("FAIL drain_count bytes=%0d lvl=%0d want 513/0", ncons, lvl0);
        end
    endtask

    task automatic test_stream();
        int hs;
        bit prev_hold;
        bit r, b;
        logic [7:0] prev_byte;
        pulse_rst();
        hs = 0;
        for (int c = 0; c < 300; c++) begin
            drive0(1, 1'($urandom_range(0, 1)), 1);
            n_cmp++;
            if (lvl0 !== 13'(bitq.size()) || byv0 !== holding) begin
                n_err++;
                $display("FAIL stream_state cyc=%0d lvl=%0d vld=%b want %0d/%b", c, lvl0, byv0, bitq.size(), holding);
            end
            if (byv0) begin
                n_cmp++;
                if (bo0 !== hold_byte) begin
                    n_err++;
                    $display("FAIL stream_byte cyc=%0d got=%h want=%h", c, bo0, hold_byte);
                end
                if (c >= 100 && c < 180) hs++;
            end
            model_step(1, bi0, 1);
        end
        n_cmp++;
        if (hs != 10) begin
            n_err++;
            $display("FAIL stream_rate bytes_in_80_cycles=%0d want 10", hs);
        end
        prev_hold = 1'b0;
        prev_byte = '0;
        for (int c = 0; c < 400; c++) begin
            r = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            drive0(1, b, r);
            if (prev_hold) begin
                n_cmp++;
                if (byv0 !== 1'b1 || bo0 !== prev_byte) begin
                    n_err++;
                    $display("FAIL backpressure_hold cyc=%0d vld=%b byte=%h want 1/%h", c, byv0, bo0, prev_byte);
                end
            end
            n_cmp++;
            if (lvl0 !== 13'(bitq.size()) || byv0 !== holding || (byv0 && bo0 !== hold_byte)) begin
                n_err++;
                $display("FAIL bp_state cyc=%0d lvl=%0d vld=%b byte=%h want %0d/%b/%h",
                         c, lvl0, byv0, bo0, bitq.size(), holding, hold_byte);
            end
            prev_hold = byv0 && !r;
            prev_byte = bo0;
            model_step(1, b, r);
        end
    endtask

    task automatic test_wrap();
        int nacc, wrap_a, wrap_b, c;
        bit v, b, r;
        pulse_rst();
        nacc = 0; wrap_a = 0; wrap_b = 0; c = 0;
        while (nacc < 10000 && c < 40000) begin
            v = ($urandom_range(0, 3) != 0);
            b = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 2) != 0);
            drive0(v, b, r);
            n_cmp++;
            if (lvl0 !== 13'(bitq.size()) || byv0 !== holding || brdy0 !== (bitq.size() != 4096) ||
                af0 !== (bitq.size() >= 4032) || (byv0 && r && bo0 !== hold_byte)) begin
                n_err++;
                $display("FAIL wrap_state cyc=%0d lvl=%0d vld=%b byte=%h want %0d/%b/%h",
                         c, lvl0, byv0, bo0, bitq.size(), holding, hold_byte);
            end
            if (ena0 && addra0 == 12'd4095) wrap_a++;
            if (enb0 && addrb0 == 9'd511) wrap_b++;
            if (v && bitq.size() != 4096) nacc++;
            model_step(v, b, r);
            c++;
        end
        n_cmp++;
        if (nacc < 10000 || wrap_a < 2 || wrap_b < 1) begin
            n_err++;
            $display("FAIL wrap_cover accepted=%0d addra_wraps=%0d addrb_wraps=%0d", nacc, wrap_a, wrap_b);
        end
    endtask

    task automatic test_partial();
        pulse_rst();
        for (int i = 0; i < 16; i++) begin
            drive0(1, 1'($urandom_range(0, 1)), 0);
            model_step(bv0, bi0, 0);
        end
        drive0(1, 1, 1);
        n_cmp++;
        if (lvl0 !== 13'd8 || byv0 !== 1'b1 || bo0 !== hold_byte) begin
            n_err++;
            $display("FAIL partial_pre lvl=%0d vld=%b byte=%h want 8/1/%h", lvl0, byv0, bo0, hold_byte);
        end
        model_step(1, 1, 1);
        drive0(0, 0, 1);
        n_cmp++;
        if (lvl0 !== 13'd1 || byv0 !== 1'b1 || bo0 !== hold_byte) begin
            n_err++;
            $display("FAIL partial_sim lvl=%0d vld=%b byte=%h want 1/1/%h", lvl0, byv0, bo0, hold_byte);
        end
        model_step(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive0(0, 0, 1);
            n_cmp++;
            if (lvl0 !== 13'd1 || byv0 !== 1'b0) begin
                n_err++;
                $display("FAIL partial_held lvl=%0d vld=%b want 1/0", lvl0, byv0);
            end
            model_step(0, 0, 1);
        end
        for (int i = 0; i < 7; i++) begin
            drive0(1, 1'($urandom_range(0, 1)), 0);
            n_cmp++;
            if (byv0 !== 1'b0 || lvl0 !== 13'(1 + i)) begin
                n_err++;
                $display("FAIL partial_fill i=%0d vld=%b lvl=%0d want 0/%0d", i, byv0, lvl0, 1 + i);
            end
            model_step(bv0, bi0, 0);
        end
        drive0(0, 0, 0);
        model_step(0, 0, 0);
        drive0(0, 0, 1);
        n_cmp++;
        if (byv0 !== 1'b1 || bo0 !== hold_byte || lvl0 !== 13'd0 || bo0[0] !== 1'b1) begin
            n_err++;
            $display("FAIL partial_done vld=%b byte=%h lvl=%0d want 1/%h/0", byv0, bo0, lvl0, hold_byte);
        end
        model_step(0, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        bi0 = 0; bv0 = 0; br0 = 0;
        bi1 = 0; bv1 = 0; br1 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_msb_first();
        test_fill();
        test_stream();
        test_wrap();
        test_partial();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
